// File: rtl/proc_control.sv
// Control-unit FSM for the shared-bus processor: decodes IR = {III, XXX, YYY}
// into per-cycle register, bus-source and ALU strobes over up to four T-steps.
module proc_control (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [8:0] IR,
  output logic       IRin,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       DINout,
  output logic       Gout,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       Done,
  output logic [1:0] Tstep
);

  localparam logic [1:0] T0 = 2'b00;
  localparam logic [1:0] T1 = 2'b01;
  localparam logic [1:0] T2 = 2'b10;
  localparam logic [1:0] T3 = 2'b11;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // 3-to-8 one-hot decode; all-zero when the enable is low.
  function automatic logic [7:0] dec3to8(input logic [2:0] n, input logic en);
    logic [7:0] one_hot;
    one_hot = 8'h01 << n;
    return en ? one_hot : 8'h00;
  endfunction

  logic [1:0] tstep_reg;
  logic [1:0] tstep_next;
  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;

  logic       irin_next;
  logic       rin_en_next;
  logic       rout_en_next;
  logic [2:0] rout_sel_next;
  logic       dinout_next;
  logic       gout_next;
  logic       ain_next;
  logic       gin_next;
  logic       addsub_next;
  logic       done_next;

  assign op = IR[8:6];
  assign rx = IR[5:3];
  assign ry = IR[2:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tstep_reg <= T0;
    end else begin
      tstep_reg <= tstep_next;
    end
  end

  always_comb begin
    tstep_next    = tstep_reg;
    irin_next     = 1'b0;
    rin_en_next   = 1'b0;
    rout_en_next  = 1'b0;
    rout_sel_next = ry;
    dinout_next   = 1'b0;
    gout_next     = 1'b0;
    ain_next      = 1'b0;
    gin_next      = 1'b0;
    addsub_next   = 1'b0;
    done_next     = 1'b0;

    case (tstep_reg)
      T0: begin
        irin_next = Run;
        if (Run) begin
          tstep_next = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            rout_en_next  = 1'b1;
            rout_sel_next = ry;
            rin_en_next   = 1'b1;
            done_next     = 1'b1;
            tstep_next    = T0;
          end
          OP_MVI: begin
            dinout_next = 1'b1;
            rin_en_next = 1'b1;
            done_next   = 1'b1;
            tstep_next  = T0;
          end
          OP_ADD, OP_SUB: begin
            rout_en_next  = 1'b1;
            rout_sel_next = rx;
            ain_next      = 1'b1;
            tstep_next    = T2;
          end
          default: begin
            // Undefined opcodes retire as a NOP without touching the bus.
            done_next  = 1'b1;
            tstep_next = T0;
          end
        endcase
      end
      T2: begin
        rout_en_next  = 1'b1;
        rout_sel_next = ry;
        gin_next      = 1'b1;
        addsub_next   = (op == OP_SUB);
        tstep_next    = T3;
      end
      default: begin
        gout_next   = 1'b1;
        rin_en_next = 1'b1;
        done_next   = 1'b1;
        tstep_next  = T0;
      end
    endcase
  end

  // Reset masks every strobe so an aborted instruction can neither write nor retire.
  assign IRin   = irin_next   & ~Reset;
  assign Rin    = dec3to8(rx, rin_en_next & ~Reset);
  assign Rout   = dec3to8(rout_sel_next, rout_en_next & ~Reset);
  assign DINout = dinout_next & ~Reset;
  assign Gout   = gout_next   & ~Reset;
  assign Ain    = ain_next    & ~Reset;
  assign Gin    = gin_next    & ~Reset;
  assign AddSub = addsub_next & ~Reset;
  assign Done   = done_next   & ~Reset;
  assign Tstep  = tstep_reg;

endmodule

// File: tb/tb_proc_control.sv
// Bench for proc_control: directed vector table followed by random instruction
// streams checked against a micro-step queue model of the instruction set.
module tb_proc_control;

  typedef struct {
    logic [1:0] tstep;
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       dinout;
    logic       gout;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       run;
    logic [8:0] ir;
    outs_t      e;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       run_i;
  logic [8:0] ir_i;
  logic       irin;
  logic [7:0] rin;
  logic [7:0] rout;
  logic       dinout;
  logic       gout;
  logic       ain;
  logic       gin;
  logic       addsub;
  logic       done;
  logic [1:0] tstep;

  int n_checks = 0;
  int n_fail   = 0;

  proc_control dut (
    .Clock (clk),
    .Reset (reset),
    .Run   (run_i),
    .IR    (ir_i),
    .IRin  (irin),
    .Rin   (rin),
    .Rout  (rout),
    .DINout(dinout),
    .Gout  (gout),
    .Ain   (ain),
    .Gin   (gin),
    .AddSub(addsub),
    .Done  (done),
    .Tstep (tstep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t o(input logic [1:0] t, input logic ir_ld, input logic [7:0] ri,
                              input logic [7:0] ro, input logic di, input logic go,
                              input logic a, input logic g, input logic as, input logic d);
    outs_t r;
    r.tstep = t; r.irin = ir_ld; r.rin = ri; r.rout = ro; r.dinout = di;
    r.gout = go; r.ain = a; r.gin = g; r.addsub = as; r.done = d;
    return r;
  endfunction

  function automatic vec_t v(input logic rs, input logic rn, input logic [8:0] ir, input outs_t e);
    vec_t r;
    r.rst = rs; r.run = rn; r.ir = ir; r.e = e;
    return r;
  endfunction

  task automatic chk(input string tag, input int idx, input string name,
                     input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] %s: got %h expected %h", tag, idx, name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then compare every output against e.
  task automatic apply(input logic rs, input logic rn, input logic [8:0] ir,
                       input outs_t e, input string tag, input int idx);
    int busy;
    @(negedge clk);
    reset = rs; run_i = rn; ir_i = ir;
    #1;
    chk(tag, idx, "tstep",  {6'b0, tstep},  {6'b0, e.tstep});
    chk(tag, idx, "irin",   {7'b0, irin},   {7'b0, e.irin});
    chk(tag, idx, "rin",    rin,            e.rin);
    chk(tag, idx, "rout",   rout,           e.rout);
    chk(tag, idx, "dinout", {7'b0, dinout}, {7'b0, e.dinout});
    chk(tag, idx, "gout",   {7'b0, gout},   {7'b0, e.gout});
    chk(tag, idx, "ain",    {7'b0, ain},    {7'b0, e.ain});
    chk(tag, idx, "gin",    {7'b0, gin},    {7'b0, e.gin});
    chk(tag, idx, "addsub", {7'b0, addsub}, {7'b0, e.addsub});
    chk(tag, idx, "done",   {7'b0, done},   {7'b0, e.done});
    busy = int'(rout != 8'h00) + int'(dinout) + int'(gout);
    n_checks++;
    if (busy > 1) begin
      n_fail++;
      $display("FAIL %s[%0d] bus_excl: got %0d drivers expected at most 1", tag, idx, busy);
    end
    $display("%s[%0d] rst=%b run=%b ir=%b tstep=%0d irin=%b rin=%h rout=%h din=%b gout=%b ain=%b gin=%b as=%b done=%b",
             tag, idx, rs, rn, ir, tstep, irin, rin, rout, dinout, gout, ain, gin, addsub, done);
  endtask

  // Reference model: an instruction is a list of post-fetch micro-steps.
  outs_t model_q[$];

  task automatic push_instr(input logic [8:0] ir);
    logic [2:0] op;
    logic [7:0] dx;
    logic [7:0] dy;
    op = ir[8:6];
    dx = 8'h01 << ir[5:3];
    dy = 8'h01 << ir[2:0];
    case (op)
      3'd0: model_q.push_back(o(2'd1, 0, dx, dy, 0, 0, 0, 0, 0, 1));
      3'd1: model_q.push_back(o(2'd1, 0, dx, 8'h00, 1, 0, 0, 0, 0, 1));
      3'd2, 3'd3: begin
        model_q.push_back(o(2'd1, 0, 8'h00, dx, 0, 0, 1, 0, 0, 0));
        model_q.push_back(o(2'd2, 0, 8'h00, dy, 0, 0, 0, 1, (op == 3'd3), 0));
        model_q.push_back(o(2'd3, 0, dx, 8'h00, 0, 1, 0, 0, 0, 1));
      end
      default: model_q.push_back(o(2'd1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
    endcase
  endtask

  localparam logic [8:0] I_MVI_R2  = 9'b001_010_000;
  localparam logic [8:0] I_MV_R5R3 = 9'b000_101_011;
  localparam logic [8:0] I_SUB_R1R6 = 9'b011_001_110;
  localparam logic [8:0] I_ADD_R3R3 = 9'b010_011_011;
  localparam logic [8:0] I_MVI_R7  = 9'b001_111_000;
  localparam logic [8:0] I_UNDEF   = 9'b110_000_000;
  localparam logic [8:0] I_ADD_R1R2 = 9'b010_001_010;

  vec_t tbl[23];
  vec_t abort_seq[6];

  initial begin
    logic [8:0] rir;
    logic       rrst;
    logic       rrun;
    outs_t      e;
    outs_t      z;

    z = o(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    // Fields: tstep irin rin rout din gout ain gin addsub done
    tbl[0]  = v(1, 1, I_ADD_R3R3, z);
    tbl[1]  = v(0, 1, I_MVI_R2,   o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl[2]  = v(0, 0, I_MVI_R2,   o(1, 0, 8'h04, 8'h00, 1, 0, 0, 0, 0, 1));
    tbl[3]  = v(0, 0, I_MVI_R2,   z);
    tbl[4]  = v(0, 1, I_MV_R5R3,  o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl[5]  = v(0, 0, I_MV_R5R3,  o(1, 0, 8'h20, 8'h08, 0, 0, 0, 0, 0, 1));
    tbl[6]  = v(0, 1, I_SUB_R1R6, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl[7]  = v(0, 0, I_SUB_R1R6, o(1, 0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0));
    tbl[8]  = v(0, 1, I_SUB_R1R6, o(2, 0, 8'h00, 8'h40, 0, 0, 0, 1, 1, 0));
    tbl[9]  = v(0, 0, I_SUB_R1R6, o(3, 0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1));
    tbl[10] = v(0, 0, I_SUB_R1R6, z);
    tbl[11] = v(0, 1, I_ADD_R3R3, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl[12] = v(0, 1, I_ADD_R3R3, o(1, 0, 8'h00, 8'h08, 0, 0, 1, 0, 0, 0));
    tbl[13] = v(0, 1, I_ADD_R3R3, o(2, 0, 8'h00, 8'h08, 0, 0, 0, 1, 0, 0));
    tbl[14] = v(0, 1, I_ADD_R3R3, o(3, 0, 8'h08, 8'h00, 0, 1, 0, 0, 0, 1));
    tbl[15] = v(0, 1, I_MVI_R7,   o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl[16] = v(0, 1, I_MVI_R7,   o(1, 0, 8'h80, 8'h00, 1, 0, 0, 0, 0, 1));
    tbl[17] = v(0, 0, I_UNDEF,    z);
    tbl[18] = v(0, 1, I_UNDEF,    o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl[19] = v(0, 0, I_UNDEF,    o(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
    tbl[20] = v(0, 0, I_UNDEF,    z);
    tbl[21] = v(0, 0, 9'b000_011_011, z);
    tbl[22] = v(0, 1, 9'b000_011_011, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));

    // Reset held for two cycles starting in T2 of an add aborts it silently.
    abort_seq[0] = v(0, 0, 9'b000_011_011, o(1, 0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1));
    abort_seq[1] = v(0, 1, I_ADD_R1R2, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    abort_seq[2] = v(0, 0, I_ADD_R1R2, o(1, 0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0));
    abort_seq[3] = v(1, 0, I_ADD_R1R2, o(2, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    abort_seq[4] = v(1, 0, I_ADD_R1R2, z);
    abort_seq[5] = v(0, 0, I_ADD_R1R2, z);

    reset = 1'b1; run_i = 1'b0; ir_i = 9'd0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 23; i++)
      apply(tbl[i].rst, tbl[i].run, tbl[i].ir, tbl[i].e, "vec", i);
    for (int i = 0; i < 6; i++)
      apply(abort_seq[i].rst, abort_seq[i].run, abort_seq[i].ir, abort_seq[i].e, "abort", i);
    apply(0, 0, I_ADD_R1R2, z, "abort", 6);

    // Random instruction stream; IR only changes while the model is idle.
    model_q.delete();
    rir = 9'd0;
    for (int c = 0; c < 600; c++) begin
      rrst = ($urandom_range(0, 29) == 0);
      rrun = 1'($urandom_range(0, 1));
      if (model_q.size() == 0) rir = 9'($urandom);
      if (rrst) begin
        e = z;
        e.tstep = (model_q.size() == 0) ? 2'd0 : model_q[0].tstep;
      end else if (model_q.size() == 0) begin
        e = z;
        e.irin = rrun;
      end else begin
        e = model_q[0];
      end
      apply(rrst, rrun, rir, e, "rand", c);
      if (rrst) model_q.delete();
      else if (model_q.size() == 0) begin
        if (rrun) push_instr(rir);
      end else begin
        void'(model_q.pop_front());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
